conv_encoder_k7: RTL
====================

Name: conv_encoder_k7

Overview:
- Rate-1/2, constraint-length-7 feedforward convolutional encoder; the transmit-side counterpart of the 64-state Viterbi decoder.
- Takes a framed serial bit stream over a valid/ready handshake and emits one 2-bit code symbol per input bit.
- Appends K-1 zero tail bits per frame so the trellis terminates in state 0, the state the decoder's traceback expects.
- Sits between the frame source and the channel model / decoder testbench.

Parameters:
- K, 7, constraint length; state register is K-1 = 6 bits (64 states).
- G0, 7'o171, generator for sym_pair[0]; MSB taps the current input bit.
- G1, 7'o133, generator for sym_pair[1]; MSB taps the current input bit.
- TAIL_EN, 1, 1 = append K-1 zero tail bits after in_last; 0 = no tail, state cleared after in_last.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit/in_last valid.
- in_ready  out  1  encoder accepts input this cycle.
- in_bit  in  1  information bit.
- in_last  in  1  marks final information bit of the frame.
- sym_valid  out  1  sym_pair valid.
- sym_ready  in  1  downstream accepts symbol.
- sym_pair  out  2  code symbol; [0] = G0 parity, [1] = G1 parity.
- sym_last  out  1  marks final symbol of the frame (last tail symbol if TAIL_EN).

Behaviour:
- Reset (rst=1 at an edge):
  - state register s = 0, FSM = RUN, tail counter = 0.
  - sym_valid = 0, sym_pair = 0, sym_last = 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-frame or mid-tail abandons the frame with no further symbols.
- Window: w = {b, s[K-2:0]}.
  - b = in_bit in RUN, 0 in TAIL.
  - s[K-2] is the most recent previous bit.
- Outputs: c0 = XOR-reduce(w & G0), c1 = XOR-reduce(w & G1).
- Next state: s <= w[K-1:1].
- Output register: single-entry.
  - Loads {c1,c0} when a step fires.
  - Holds sym_pair and sym_last stable while sym_valid=1 and sym_ready=0.
  - A step may fire when sym_valid=0 or sym_ready=1 (full throughput, no bubble).
- Latency: a symbol is visible on sym_pair one cycle after its input handshake.
- FSM RUN:
  - in_ready = (!sym_valid || sym_ready).
  - A step fires on in_valid && in_ready.
  - in_last accepted with TAIL_EN=1: go to TAIL with tail counter = K-1; the symbol for in_last has sym_last=0.
  - in_last accepted with TAIL_EN=0: that symbol has sym_last=1, s is cleared to 0 on the same edge, FSM stays in RUN.
- FSM TAIL:
  - in_ready = 0.
  - Each cycle with (!sym_valid || sym_ready): step with b=0 and decrement the counter.
  - The step taken at counter = 1 sets sym_last=1 and returns to RUN; s is then 0 by construction.
- Frame size: K-1 = 6 tail symbols per frame. A frame of N bits yields N+6 symbols (TAIL_EN=1) or N symbols (TAIL_EN=0).
- Back-to-back frames:
  - The next frame's first bit is accepted in the cycle after sym_last is loaded into the output register, subject to backpressure.
  - No bits are accepted during TAIL.
- Simultaneous sym_ready with a new step: the old symbol is consumed and the new one loaded on the same edge.
- in_valid=0 in RUN: no state change; sym_valid drops after the held symbol is consumed.
- in_bit/in_last are ignored when in_ready=0.

Decomposition:
- Package conv_pkg:
  - constants K_DEF=7, G0_DEF=7'o171, G1_DEF=7'o133.
  - parity function (XOR-reduce of masked window).
  - FSM enum {RUN, TAIL}.
- Sub-module conv_branch_out: purely combinational, window -> 2-bit symbol. Reusable by the decoder's branch-label generation and by the bench's reference model.

Test Plan:
- Impulse: frame {1}, in_last=1, sym_ready=1.
  - Symbols {c1,c0} = 11, 01, 11, 11, 00, 10, 11.
  - sym_last only on the 7th symbol; in_ready=0 for the 6 tail cycles.
- All-zero frame of 10 bits:
  - 16 symbols, all 00, sym_last on the 16th.
  - s = 0 afterwards.
- Backpressure: impulse frame with sym_ready toggling 1,0,0,1,…
  - Same 7-symbol sequence, no loss or duplication.
  - sym_pair stable whenever sym_valid=1 and sym_ready=0.
- Back-to-back frames {1},{1} with in_valid held high:
  - Two identical 7-symbol impulse responses, each with its own sym_last.
  - Zero idle cycles between frames when sym_ready=1.
- Reset mid-tail: rst asserted after the 3rd tail symbol.
  - Next cycle: sym_valid=0, in_ready=1.
  - A following impulse frame produces the exact impulse response (state cleared).
- TAIL_EN=0, frame {1,0,1}:
  - Symbols 11, 01, 00.
  - sym_last on the 3rd symbol; next frame starts from state 0.

Source files
------------

// File: rtl/conv_encoder_k7_pkg.sv
// conv_pkg: shared constants, FSM states and parity helper for the K=7 convolutional encoder
package conv_pkg;
    localparam int K_DEF = 7;
    localparam logic [K_DEF-1:0] G0_DEF = 7'o171;
    localparam logic [K_DEF-1:0] G1_DEF = 7'o133;
    typedef enum logic {RUN, TAIL} state_t;
    function automatic logic parity(input logic [31:0] window, input logic [31:0] gen);
        return ^(window & gen);
    endfunction
endpackage

// File: rtl/conv_encoder_k7_if.sv
// conv_encoder_k7_if: serial bit input stream and 2-bit code symbol output stream
interface conv_encoder_k7_if;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic in_last;
    logic sym_valid;
    logic sym_ready;
    logic [1:0] sym_pair;
    logic sym_last;
    modport master (
        output in_valid, in_bit, in_last, sym_ready,
        input in_ready, sym_valid, sym_pair, sym_last
    );
    modport slave (
        input in_valid, in_bit, in_last, sym_ready,
        output in_ready, sym_valid, sym_pair, sym_last
    );
endinterface

// File: rtl/conv_encoder_k7_branch_out.sv
// conv_branch_out: maps a K-bit trellis window to its {c1,c0} code symbol
module conv_branch_out
    import conv_pkg::*;
#(
    parameter int K = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic [K-1:0] window,
    output logic [1:0]   sym
);
    assign sym = {parity(32'(window), 32'(G1)), parity(32'(window), 32'(G0))};
endmodule

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: rate-1/2 K=7 feedforward convolutional encoder with optional zero-tail termination
module conv_encoder_k7
    import conv_pkg::*;
#(
    parameter int K = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF,
    parameter bit TAIL_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    conv_encoder_k7_if.slave bus
);
    localparam int CW = $clog2(K);
    state_t state, state_nx;
    logic [K-2:0] s, s_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [K-1:0] w;
    logic [1:0] sym;
    logic can_step, step, last_nx;

    conv_branch_out #(.K(K), .G0(G0), .G1(G1)) u_branch (.window(w), .sym(sym));

    // Tail steps shift zeros in, so s reaches 0 exactly when the counter expires
    always_comb begin
        can_step = !bus.sym_valid || bus.sym_ready;
        bus.in_ready = state == RUN && can_step;
        step = state == RUN ? bus.in_valid && can_step : can_step;
        w = {state == RUN && bus.in_bit, s};
        state_nx = state;
        cnt_nx = cnt;
        s_nx = w[K-1:1];
        last_nx = 1'b0;
        if (state == RUN) begin
            if (bus.in_last) begin
                state_nx = TAIL_EN ? TAIL : RUN;
                cnt_nx = TAIL_EN ? CW'(K - 1) : '0;
                last_nx = !TAIL_EN;
                s_nx = TAIL_EN ? w[K-1:1] : '0;
            end
        end else begin
            cnt_nx = cnt - 1'b1;
            state_nx = cnt == CW'(1) ? RUN : TAIL;
            last_nx = cnt == CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            s <= '0;
            cnt <= '0;
            bus.sym_valid <= 1'b0;
            bus.sym_pair <= '0;
            bus.sym_last <= 1'b0;
        end else if (step) begin
            state <= state_nx;
            s <= s_nx;
            cnt <= cnt_nx;
            bus.sym_valid <= 1'b1;
            bus.sym_pair <= sym;
            bus.sym_last <= last_nx;
        end else if (bus.sym_ready) begin
            bus.sym_valid <= 1'b0;
        end
    end
endmodule
